// File: rtl/usb_out_ep_buf_if.sv
// Bundles the token/receive path, handshake request and client-side buffer port of an OUT endpoint.
// The buffer side is the master; the protocol engine and the endpoint client together form the slave side.
interface usb_out_ep_buf_if;
    logic       token_valid;
    logic [3:0] token_pid;
    logic [3:0] token_endp;
    logic       rx_pkt_start;
    logic [3:0] rx_pid;
    logic       rx_data_put;
    logic [7:0] rx_data;
    logic       rx_pkt_end;
    logic       rx_pkt_valid;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       out_ep_req;
    logic       out_ep_grant;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;

    modport master (
        input  token_valid, token_pid, token_endp,
        input  rx_pkt_start, rx_pid, rx_data_put, rx_data, rx_pkt_end, rx_pkt_valid,
        output hs_req, hs_pid,
        input  out_ep_req, out_ep_data_get, out_ep_stall,
        output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked
    );

    modport slave (
        output token_valid, token_pid, token_endp,
        output rx_pkt_start, rx_pid, rx_data_put, rx_data, rx_pkt_end, rx_pkt_valid,
        input  hs_req, hs_pid,
        output out_ep_req, out_ep_data_get, out_ep_stall,
        input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked
    );
endinterface

// File: rtl/usb_out_ep_buf.sv
// Single-packet OUT endpoint buffer: captures SETUP/OUT payloads, answers ACK/NAK/STALL,
// tracks the DATA0/DATA1 toggle and hands the accepted payload to one client.
module usb_out_ep_buf #(
    parameter int ENDP    = 0,
    parameter int MAX_PKT = 32
) (
    input logic              clk,
    input logic              reset,
    usb_out_ep_buf_if.master bus
);
    localparam int AW = $clog2(MAX_PKT);
    localparam int PW = AW + 1;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [1:0] {READY, PUTTING, DISCARD, GETTING} state_t;
    state_t state_reg, state_next;

    logic [7:0]    mem [MAX_PKT];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, len_reg;
    logic          tog_reg, pkt_setup_reg, setup_reg;
    logic          pend_stall_reg, pend_nak_reg;
    logic          hs_req_reg, acked_reg, grant_reg;
    logic [3:0]    hs_pid_reg, rx_pid_reg;
    logic [7:0]    data_reg;

    logic       tok_setup, tok_out, take_setup, take_out;
    logic       overflow, pid_ok, accept, avail, get_ok;
    logic       hs_next, acked_next;
    logic [3:0] hs_pid_next, pid_cur;

    assign tok_setup  = bus.token_valid && bus.token_endp == 4'(ENDP) && bus.token_pid == PID_SETUP;
    assign tok_out    = bus.token_valid && bus.token_endp == 4'(ENDP) && bus.token_pid == PID_OUT;
    assign take_setup = tok_setup && (state_reg == READY || state_reg == GETTING);
    assign take_out   = tok_out && state_reg == READY;
    assign overflow   = state_reg == PUTTING && bus.rx_data_put && wr_ptr_reg == PW'(MAX_PKT);
    assign pid_cur    = bus.rx_pkt_start ? bus.rx_pid : rx_pid_reg;
    assign pid_ok     = pid_cur == (tog_reg ? PID_DATA1 : PID_DATA0);
    assign accept     = state_reg == PUTTING && !overflow && bus.rx_pkt_end && bus.rx_pkt_valid && pid_ok;
    assign get_ok     = bus.out_ep_data_get && grant_reg && avail;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= READY;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            READY: begin
                if (tok_setup)    state_next = PUTTING;
                else if (tok_out) state_next = bus.out_ep_stall ? DISCARD : PUTTING;
            end
            PUTTING: begin
                if (overflow)             state_next = DISCARD;
                else if (bus.rx_pkt_end)  state_next = accept ? GETTING : READY;
            end
            DISCARD: if (bus.rx_pkt_end) state_next = READY;
            GETTING: begin
                if (tok_setup)                   state_next = PUTTING;
                else if (rd_ptr_reg == len_reg)  state_next = READY;
            end
            default: state_next = READY;
        endcase
    end

    // A handshake goes out on the cycle after rx_pkt_end; outside PUTTING only a pending STALL/NAK is sent.
    always_comb begin
        hs_next     = 1'b0;
        hs_pid_next = 4'h0;
        acked_next  = 1'b0;
        avail       = state_reg == GETTING && rd_ptr_reg < len_reg;
        if (bus.rx_pkt_end) begin
            if (state_reg == PUTTING) begin
                if (!overflow && bus.rx_pkt_valid) begin
                    hs_next     = 1'b1;
                    hs_pid_next = PID_ACK;
                    acked_next  = accept;
                end
            end else if (pend_stall_reg) begin
                hs_next     = 1'b1;
                hs_pid_next = PID_STALL;
            end else if (pend_nak_reg) begin
                hs_next     = 1'b1;
                hs_pid_next = PID_NAK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            len_reg        <= '0;
            tog_reg        <= 1'b0;
            pkt_setup_reg  <= 1'b0;
            setup_reg      <= 1'b0;
            pend_stall_reg <= 1'b0;
            pend_nak_reg   <= 1'b0;
            hs_req_reg     <= 1'b0;
            hs_pid_reg     <= 4'h0;
            acked_reg      <= 1'b0;
            grant_reg      <= 1'b0;
            rx_pid_reg     <= 4'h0;
        end else begin
            hs_req_reg <= hs_next;
            hs_pid_reg <= hs_pid_next;
            acked_reg  <= acked_next;
            grant_reg  <= bus.out_ep_req && state_reg == GETTING;
            if (bus.rx_pkt_start) rx_pid_reg <= bus.rx_pid;
            if (get_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (state_reg == PUTTING && bus.rx_data_put && !overflow)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (accept) begin
                len_reg   <= wr_ptr_reg;
                tog_reg   <= ~tog_reg;
                setup_reg <= pkt_setup_reg;
            end
            if (state_reg == GETTING && state_next == READY) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end
            // Token handling last so a SETUP flush overrides a same-cycle client read.
            if (take_setup) begin
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                tog_reg        <= 1'b0;
                pkt_setup_reg  <= 1'b1;
                pend_stall_reg <= 1'b0;
                pend_nak_reg   <= 1'b0;
            end else if (take_out) begin
                wr_ptr_reg     <= '0;
                pkt_setup_reg  <= 1'b0;
                pend_stall_reg <= bus.out_ep_stall;
                pend_nak_reg   <= 1'b0;
            end else if (state_reg == GETTING && tok_out) begin
                pend_nak_reg <= 1'b1;
            end else if (bus.rx_pkt_end && state_reg != PUTTING) begin
                pend_stall_reg <= 1'b0;
                pend_nak_reg   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == PUTTING && bus.rx_data_put && wr_ptr_reg < PW'(MAX_PKT))
            mem[wr_ptr_reg[AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset)       data_reg <= 8'h00;
        else if (get_ok) data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    assign bus.hs_req            = hs_req_reg;
    assign bus.hs_pid            = hs_pid_reg;
    assign bus.out_ep_acked      = acked_reg;
    assign bus.out_ep_grant      = grant_reg;
    assign bus.out_ep_data_avail = avail;
    assign bus.out_ep_setup      = setup_reg;
    assign bus.out_ep_data       = data_reg;
endmodule

// File: tb/tb_usb_out_ep_buf.sv
// Bench for usb_out_ep_buf: directed scenarios followed by random packets, all checked
// against a packet-level model of the endpoint (unread-byte queue, expected toggle, setup flag).
module tb_usb_out_ep_buf;
    localparam int ENDP    = 0;
    localparam int MAX_PKT = 32;
    localparam logic [3:0] P_OUT = 4'h1, P_SETUP = 4'hD, P_IN = 4'h9;
    localparam logic [3:0] D0 = 4'h3, D1 = 4'hB;
    localparam logic [3:0] H_ACK = 4'h2, H_NAK = 4'hA, H_STALL = 4'hE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] pay [64];
    logic [7:0] exp_q [$];
    bit         m_tog;
    bit         m_setup;

    usb_out_ep_buf_if bus();

    usb_out_ep_buf #(.ENDP(ENDP), .MAX_PKT(MAX_PKT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] out_vec();
        return {bus.hs_req, bus.hs_pid, bus.out_ep_grant, bus.out_ep_data_avail,
                bus.out_ep_setup, bus.out_ep_data, bus.out_ep_acked};
    endfunction

    // Drives one token + data packet, predicts the handshake from the endpoint rules, and checks it.
    task automatic send_pkt(input logic [3:0] tp, input logic [3:0] ep, input logic [3:0] dp,
                            input int n, input bit ok);
        bit         exp_hs = 0;
        bit         exp_ack = 0;
        logic [3:0] exp_pid = 4'h0;
        if (ep == 4'(ENDP) && (tp == P_OUT || tp == P_SETUP)) begin
            if (tp == P_SETUP) begin
                exp_q.delete();
                m_tog = 0;
            end
            if (tp == P_OUT && exp_q.size() > 0) begin
                exp_hs = 1; exp_pid = H_NAK;
            end else if (tp == P_OUT && bus.out_ep_stall) begin
                exp_hs = 1; exp_pid = H_STALL;
            end else if (ok && n <= MAX_PKT) begin
                exp_hs = 1; exp_pid = H_ACK;
                if (dp == (m_tog ? D1 : D0)) begin
                    exp_ack = 1;
                    m_tog   = !m_tog;
                    m_setup = (tp == P_SETUP);
                    for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
                end
            end
        end
        bus.token_valid = 1; bus.token_pid = tp; bus.token_endp = ep;
        tick();
        bus.token_valid = 0;
        tick();
        tick();
        bus.rx_pkt_start = 1; bus.rx_pid = dp;
        tick();
        bus.rx_pkt_start = 0;
        for (int i = 0; i < n; i++) begin
            bus.rx_data_put = 1; bus.rx_data = pay[i];
            tick();
        end
        bus.rx_data_put = 0;
        bus.rx_pkt_end = 1; bus.rx_pkt_valid = ok;
        tick();
        bus.rx_pkt_end = 0; bus.rx_pkt_valid = 0;
        $display("pkt tok=%h ep=%0d pid=%h len=%0d crc_ok=%0d stall=%0d -> hs=%0d/%h acked=%0d (model %0d/%h %0d)",
                 tp, ep, dp, n, ok, bus.out_ep_stall, bus.hs_req, bus.hs_pid, bus.out_ep_acked,
                 exp_hs, exp_pid, exp_ack);
        check("hs_req", bus.hs_req, exp_hs);
        check("hs_pid", bus.hs_pid, exp_pid);
        check("acked", bus.out_ep_acked, exp_ack);
        tick();
        check("hs_single", {bus.hs_req, bus.out_ep_acked}, 2'b00);
    endtask

    // Reads k bytes through the client port (caller ensures unread data exists).
    task automatic read_n(input int k);
        logic [7:0] b;
        check("avail_pre", bus.out_ep_data_avail, 1'b1);
        check("setup", bus.out_ep_setup, m_setup);
        bus.out_ep_req = 1;
        tick();
        check("grant", bus.out_ep_grant, 1'b1);
        for (int i = 0; i < k; i++) begin
            bus.out_ep_data_get = 1;
            tick();
            bus.out_ep_data_get = 0;
            b = exp_q.pop_front();
            check("data", bus.out_ep_data, b);
        end
        bus.out_ep_req = 0;
        tick();
        check("avail_post", bus.out_ep_data_avail, exp_q.size() > 0);
        $display("read %0d bytes, %0d left", k, exp_q.size());
        tick();
    endtask

    initial begin
        logic [7:0] setup_bytes [8];
        logic [3:0] tp, ep, dp;
        int         n, k;
        bit         ok;
        setup_bytes = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
        bus.token_valid = 0; bus.token_pid = 0; bus.token_endp = 0;
        bus.rx_pkt_start = 0; bus.rx_pid = 0; bus.rx_data_put = 0; bus.rx_data = 0;
        bus.rx_pkt_end = 0; bus.rx_pkt_valid = 0;
        bus.out_ep_req = 0; bus.out_ep_data_get = 0; bus.out_ep_stall = 0;
        m_tog = 0; m_setup = 0;
        repeat (3) tick();
        reset = 0;
        tick();
        check("reset_outputs", 32'(out_vec()), 32'h0);

        // Standard GET_DESCRIPTOR setup packet
        for (int i = 0; i < 8; i++) pay[i] = setup_bytes[i];
        send_pkt(P_SETUP, 4'(ENDP), D0, 8, 1);
        read_n(8);

        // Full-size OUT, then a host retry of the same DATA1
        for (int i = 0; i < 32; i++) pay[i] = 8'(i);
        send_pkt(P_OUT, 4'(ENDP), D1, 32, 1);
        read_n(32);
        send_pkt(P_OUT, 4'(ENDP), D1, 32, 1);
        check("retry_no_avail", bus.out_ep_data_avail, 1'b0);

        // OUT while data unread -> NAK, then SETUP flushes
        for (int i = 0; i < 6; i++) pay[i] = 8'hA0 + 8'(i);
        send_pkt(P_OUT, 4'(ENDP), D0, 6, 1);
        read_n(2);
        for (int i = 0; i < 6; i++) pay[i] = 8'h55;
        send_pkt(P_OUT, 4'(ENDP), D1, 6, 1);
        bus.out_ep_data_get = 1;
        tick();
        bus.out_ep_data_get = 0;
        read_n(2);
        for (int i = 0; i < 8; i++) pay[i] = setup_bytes[7-i];
        send_pkt(P_SETUP, 4'(ENDP), D0, 8, 1);
        read_n(8);

        // STALL, then SETUP is still accepted
        bus.out_ep_stall = 1;
        send_pkt(P_OUT, 4'(ENDP), D1, 4, 1);
        send_pkt(P_SETUP, 4'(ENDP), D0, 8, 1);
        bus.out_ep_stall = 0;
        read_n(8);

        // Bad CRC and overflow leave the toggle alone
        send_pkt(P_OUT, 4'(ENDP), D1, 4, 0);
        for (int i = 0; i < 33; i++) pay[i] = 8'(i * 3);
        send_pkt(P_OUT, 4'(ENDP), D1, 33, 1);
        send_pkt(P_OUT, 4'(ENDP), D1, 0, 1);
        check("zlp_no_avail", bus.out_ep_data_avail, 1'b0);
        send_pkt(P_OUT, 4'(ENDP), D0, 3, 1);
        read_n(3);

        // Reset in the middle of a packet
        bus.token_valid = 1; bus.token_pid = P_SETUP; bus.token_endp = 4'(ENDP);
        tick();
        bus.token_valid = 0;
        bus.rx_pkt_start = 1; bus.rx_pid = D0;
        tick();
        bus.rx_pkt_start = 0;
        for (int i = 0; i < 5; i++) begin
            bus.rx_data_put = 1; bus.rx_data = 8'(i);
            tick();
        end
        bus.rx_data_put = 0;
        reset = 1;
        tick();
        reset = 0;
        tick();
        check("midpkt_reset", 32'(out_vec()), 32'h0);
        exp_q.delete(); m_tog = 0; m_setup = 0;
        for (int i = 0; i < 8; i++) pay[i] = setup_bytes[i];
        send_pkt(P_SETUP, 4'(ENDP), D0, 8, 1);
        read_n(8);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            k  = $urandom_range(0, 9);
            tp = (k < 4) ? P_SETUP : ((k < 9) ? P_OUT : P_IN);
            ep = ($urandom_range(0, 7) == 0) ? 4'd1 : 4'(ENDP);
            dp = ($urandom_range(0, 1) == 1) ? D1 : D0;
            n  = ($urandom_range(0, 7) == 0) ? MAX_PKT + 1 : $urandom_range(0, MAX_PKT);
            ok = ($urandom_range(0, 9) != 0);
            bus.out_ep_stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            send_pkt(tp, ep, dp, n, ok);
            bus.out_ep_stall = 0;
            if (exp_q.size() > 0) begin
                k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 1) : exp_q.size();
                if (k > 0) read_n(k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
